// File: rtl/led_zone_pwm_ctrl_pkg.sv
// Shared zone codes, PWM width and duty helper for the LED zone controller.
package led_zone_pwm_ctrl_pkg;

  localparam int PWM_BITS = 8;

  typedef enum logic [1:0] {
    ZONE_COLD  = 2'd0,
    ZONE_MILD  = 2'd1,
    ZONE_HOT   = 2'd2,
    ZONE_ALARM = 2'd3
  } zone_e;

  // Samples of 256 and above saturate to full-scale duty.
  function automatic logic [PWM_BITS-1:0] sat_duty(
    input logic [8:0] t
  );
    return t[8] ? '1 : t[7:0];
  endfunction

endpackage

// File: rtl/led_zone_pwm_ctrl_pwm_timebase.sv
// PWM timebase: clock prescaler plus 8-bit PWM counter.
module pwm_timebase
  import led_zone_pwm_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 195
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                tick_o,
  output logic [PWM_BITS-1:0] pwm_cnt_o,
  output logic                period_end_o
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]       ps_q;
  logic [PW-1:0]       ps_d;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;

  assign tick_o       = (ps_q == PS_LAST);
  assign period_end_o = tick_o && (cnt_q == '1);
  assign pwm_cnt_o    = cnt_q;

  always_comb begin
    ps_d  = tick_o ? '0 : ps_q + 1'b1;
    cnt_d = tick_o ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q  <= '0;
      cnt_q <= '0;
    end else begin
      ps_q  <= ps_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_zone_pwm_ctrl.sv
// Temperature-zone classifier with hysteresis driving glitch-free RGB PWM.
module led_zone_pwm_ctrl
  import led_zone_pwm_ctrl_pkg::*;
#(
  parameter int CLK_DIV       = 195,
  parameter int T_COLD        = 10,
  parameter int T_HOT         = 30,
  parameter int T_ALARM       = 60,
  parameter int HYST          = 2,
  parameter int BLINK_PERIODS = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       temp_valid,
  output logic       temp_ready,
  input  logic [8:0] temp,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic [1:0] zone,
  output logic       alarm
);

  localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIODS - 1);

  localparam logic [9:0] UP_MILD  = 10'(T_COLD + HYST);
  localparam logic [9:0] UP_HOT   = 10'(T_HOT + HYST);
  localparam logic [9:0] UP_ALARM = 10'(T_ALARM + HYST);
  localparam logic [9:0] DN_MILD  = 10'(T_COLD);
  localparam logic [9:0] DN_HOT   = 10'(T_HOT);
  localparam logic [9:0] DN_ALARM = 10'(T_ALARM);
  localparam logic [9:0] EXIT_AL  = 10'(T_ALARM - HYST);

  logic                tick;
  logic                period_end;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] cnt_nxt;

  logic                pending_q;
  logic                pending_d;
  logic [8:0]          hold_q;
  logic [8:0]          hold_d;
  zone_e               zone_q;
  zone_e               zone_d;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_d;
  logic [BW-1:0]       blink_cnt_q;
  logic [BW-1:0]       blink_cnt_d;
  logic                blink_on_q;
  logic                blink_on_d;
  logic                pwm_r_q;
  logic                pwm_g_q;
  logic                pwm_b_q;
  logic                r_nxt;
  logic                g_nxt;
  logic                b_nxt;
  logic                accept;
  logic                apply;
  logic [9:0]          t_w;

  pwm_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_tb (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_o      (tick),
    .pwm_cnt_o   (pwm_cnt),
    .period_end_o(period_end)
  );

  assign accept     = temp_valid && !pending_q;
  assign apply      = period_end && pending_q;
  assign temp_ready = !pending_q;
  assign t_w        = {1'b0, hold_q};
  assign cnt_nxt    = pwm_cnt + 1'b1;

  always_comb begin
    pending_d = pending_q;
    hold_d    = hold_q;
    if (accept) begin
      pending_d = 1'b1;
      hold_d    = temp;
    end else if (apply) begin
      pending_d = 1'b0;
    end
    duty_d = apply ? sat_duty(hold_q) : duty_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zone_q <= ZONE_COLD;
    else        zone_q <= zone_d;
  end

  // Upward moves need the hysteresis margin; HOT->ALARM is the exception.
  always_comb begin
    zone_d = zone_q;
    if (apply) begin
      if (zone_q == ZONE_ALARM) begin
        if (t_w < EXIT_AL) begin
          unique case (1'b1)
            (t_w < DN_MILD):  zone_d = ZONE_COLD;
            (t_w < DN_HOT):   zone_d = ZONE_MILD;
            default:          zone_d = ZONE_HOT;
          endcase
        end
      end else if (t_w >= UP_ALARM ||
                   (zone_q == ZONE_HOT && t_w >= DN_ALARM)) begin
        zone_d = ZONE_ALARM;
      end else if (zone_q < ZONE_HOT && t_w >= UP_HOT) begin
        zone_d = ZONE_HOT;
      end else if (zone_q == ZONE_COLD && t_w >= UP_MILD) begin
        zone_d = ZONE_MILD;
      end else if (zone_q == ZONE_HOT && t_w < DN_HOT) begin
        zone_d = (t_w < DN_MILD) ? ZONE_COLD : ZONE_MILD;
      end else if (zone_q == ZONE_MILD && t_w < DN_MILD) begin
        zone_d = ZONE_COLD;
      end
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (zone_d != ZONE_ALARM) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b0;
    end else if (zone_q != ZONE_ALARM) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (period_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Compare against the count that becomes current after this tick.
  always_comb begin
    r_nxt = 1'b0;
    g_nxt = 1'b0;
    b_nxt = 1'b0;
    unique case (zone_d)
      ZONE_COLD:  b_nxt = (duty_d > cnt_nxt);
      ZONE_MILD:  g_nxt = (duty_d > cnt_nxt);
      ZONE_HOT:   r_nxt = (duty_d > cnt_nxt);
      ZONE_ALARM: r_nxt = blink_on_d && (cnt_nxt != '1);
      default:    r_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= 1'b0;
      hold_q      <= '0;
      duty_q      <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      pwm_r_q     <= 1'b0;
      pwm_g_q     <= 1'b0;
      pwm_b_q     <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      hold_q      <= hold_d;
      duty_q      <= duty_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      if (tick) begin
        pwm_r_q <= r_nxt;
        pwm_g_q <= g_nxt;
        pwm_b_q <= b_nxt;
      end
    end
  end

  assign pwm_r = pwm_r_q;
  assign pwm_g = pwm_g_q;
  assign pwm_b = pwm_b_q;
  assign zone  = zone_q;
  assign alarm = (zone_q == ZONE_ALARM);

endmodule

// File: tb/tb_led_zone_pwm_ctrl.sv
// Directed bench for led_zone_pwm_ctrl with CLK_DIV=1, BLINK_PERIODS=2.
module tb_led_zone_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       temp_valid = 1'b0;
  logic       temp_ready;
  logic [8:0] temp = '0;
  logic       pwm_r;
  logic       pwm_g;
  logic       pwm_b;
  logic [1:0] zone;
  logic       alarm;

  int n_chk = 0;
  int n_fail = 0;

  // Expected PWM counter value, tracked independently of the DUT.
  logic [7:0] pc;

  led_zone_pwm_ctrl #(
    .CLK_DIV      (1),
    .T_COLD       (10),
    .T_HOT        (30),
    .T_ALARM      (60),
    .HYST         (2),
    .BLINK_PERIODS(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .temp_valid(temp_valid),
    .temp_ready(temp_ready),
    .temp      (temp),
    .pwm_r     (pwm_r),
    .pwm_g     (pwm_g),
    .pwm_b     (pwm_b),
    .zone      (zone),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= '0;
    else        pc <= pc + 8'd1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [8:0] t);
    temp_valid = 1'b1;
    temp = t;
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  task automatic to_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pc != 8'd0 && n < 600);
    n_chk++;
    if (pc != 8'd0) begin
      n_fail++;
      $display("FAIL to_start: no period start, pc=%0d exp 0", pc);
    end
  endtask

  task automatic measure(output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < 256; i++) begin
      r += int'(pwm_r === 1'b1);
      g += int'(pwm_g === 1'b1);
      b += int'(pwm_b === 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({pwm_r, pwm_g, pwm_b} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pwm: got %b exp 000", {pwm_r, pwm_g, pwm_b});
    end
    n_chk++;
    if (zone !== 2'd0 || alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_zone: zone=%0d alarm=%b exp 0/0", zone, alarm);
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (temp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b exp 1", temp_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_mild();
    int r, g, b;
    send(9'd20);
    to_start();
    n_chk++;
    if (zone !== 2'd1 || alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL mild_zone: zone=%0d alarm=%b exp 1/0", zone, alarm);
    end
    measure(r, g, b);
    n_chk++;
    if (g != 20 || r != 0 || b != 0) begin
      n_fail++;
      $display("FAIL mild_duty: r=%0d g=%0d b=%0d exp 0/20/0", r, g, b);
    end
  endtask

  task automatic test_hysteresis();
    int r, g, b;
    send(9'd31);
    to_start();
    n_chk++;
    if (zone !== 2'd1) begin
      n_fail++;
      $display("FAIL hyst_31: zone=%0d exp 1", zone);
    end
    send(9'd32);
    to_start();
    n_chk++;
    if (zone !== 2'd2) begin
      n_fail++;
      $display("FAIL hyst_32: zone=%0d exp 2", zone);
    end
    measure(r, g, b);
    n_chk++;
    if (r != 32 || g != 0 || b != 0) begin
      n_fail++;
      $display("FAIL hot_duty: r=%0d g=%0d b=%0d exp 32/0/0", r, g, b);
    end
    send(9'd29);
    to_start();
    n_chk++;
    if (zone !== 2'd1) begin
      n_fail++;
      $display("FAIL hyst_29: zone=%0d exp 1", zone);
    end
    send(9'd9);
    to_start();
    n_chk++;
    if (zone !== 2'd0) begin
      n_fail++;
      $display("FAIL hyst_9: zone=%0d exp 0", zone);
    end
    measure(r, g, b);
    n_chk++;
    if (b != 9 || r != 0 || g != 0) begin
      n_fail++;
      $display("FAIL cold_duty: r=%0d g=%0d b=%0d exp 0/0/9", r, g, b);
    end
  endtask

  task automatic test_handshake();
    int r, g, b;
    int n;
    send(9'd20);
    temp_valid = 1'b1;
    temp = 9'd40;
    n_chk++;
    if (temp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_busy: ready=%b exp 0", temp_ready);
    end
    repeat (3) @(negedge clk);
    temp_valid = 1'b0;
    to_start();
    n_chk++;
    if (zone !== 2'd1) begin
      n_fail++;
      $display("FAIL hs_ignored: zone=%0d exp 1", zone);
    end
    measure(r, g, b);
    n_chk++;
    if (g != 20 || r != 0) begin
      n_fail++;
      $display("FAIL hs_duty: r=%0d g=%0d exp 0/20", r, g);
    end
    n = 0;
    while (pc != 8'd255 && n < 300) begin
      @(negedge clk);
      n++;
    end
    send(9'd33);
    n_chk++;
    if (zone !== 2'd1 || temp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_late: zone=%0d ready=%b exp 1/0", zone, temp_ready);
    end
    to_start();
    n_chk++;
    if (zone !== 2'd2) begin
      n_fail++;
      $display("FAIL hs_applied: zone=%0d exp 2", zone);
    end
    measure(r, g, b);
    n_chk++;
    if (r != 33 || g != 0) begin
      n_fail++;
      $display("FAIL hs_hot_duty: r=%0d g=%0d exp 33/0", r, g);
    end
  endtask

  task automatic test_alarm();
    int r, g, b;
    int exp_r[4] = '{255, 255, 0, 0};
    send(9'd5);
    to_start();
    n_chk++;
    if (zone !== 2'd0) begin
      n_fail++;
      $display("FAIL hot_to_cold: zone=%0d exp 0", zone);
    end
    send(9'd300);
    to_start();
    n_chk++;
    if (zone !== 2'd3 || alarm !== 1'b1) begin
      n_fail++;
      $display("FAIL alarm_entry: zone=%0d alarm=%b exp 3/1", zone, alarm);
    end
    for (int p = 0; p < 4; p++) begin
      measure(r, g, b);
      n_chk++;
      if (r != exp_r[p] || g != 0 || b != 0) begin
        n_fail++;
        $display("FAIL blink_p%0d: r=%0d g=%0d b=%0d exp %0d/0/0",
                 p, r, g, b, exp_r[p]);
      end
    end
    send(9'd57);
    to_start();
    n_chk++;
    if (zone !== 2'd2 || alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL alarm_exit: zone=%0d alarm=%b exp 2/0", zone, alarm);
    end
    measure(r, g, b);
    n_chk++;
    if (r != 57 || g != 0 || b != 0) begin
      n_fail++;
      $display("FAIL exit_duty: r=%0d g=%0d b=%0d exp 57/0/0", r, g, b);
    end
  endtask

  task automatic test_duty_edges();
    int r, g, b;
    send(9'd0);
    to_start();
    n_chk++;
    if (zone !== 2'd0) begin
      n_fail++;
      $display("FAIL zero_zone: zone=%0d exp 0", zone);
    end
    measure(r, g, b);
    n_chk++;
    if (r != 0 || g != 0 || b != 0) begin
      n_fail++;
      $display("FAIL zero_duty: r=%0d g=%0d b=%0d exp 0/0/0", r, g, b);
    end
    send(9'd256);
    to_start();
    n_chk++;
    if (zone !== 2'd3) begin
      n_fail++;
      $display("FAIL sat_zone: zone=%0d exp 3", zone);
    end
    measure(r, g, b);
    n_chk++;
    if (r != 255 || g != 0 || b != 0) begin
      n_fail++;
      $display("FAIL sat_duty: r=%0d g=%0d b=%0d exp 255/0/0", r, g, b);
    end
  endtask

  task automatic test_reset_mid();
    int r, g, b;
    repeat (10) @(negedge clk);
    n_chk++;
    if (pwm_r !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: pwm_r=%b exp 1", pwm_r);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({pwm_r, pwm_g, pwm_b} !== 3'b000 || zone !== 2'd0 || alarm !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: pwm=%b zone=%0d alarm=%b exp 000/0/0",
               {pwm_r, pwm_g, pwm_b}, zone, alarm);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (temp_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_ready: got %b exp 1", temp_ready);
    end
    @(negedge clk);
    measure(r, g, b);
    n_chk++;
    if (r != 0 || g != 0 || b != 0) begin
      n_fail++;
      $display("FAIL post_reset: r=%0d g=%0d b=%0d exp 0/0/0", r, g, b);
    end
  endtask

  initial begin
    test_reset();
    test_mild();
    test_hysteresis();
    test_handshake();
    test_alarm();
    test_duty_edges();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
